flag_ctrl: RTL and testbench
============================

# flag_ctrl

Sequencing controller for the processor's N/Z/V flag register. It classifies the instruction leaving EX by opcode and computes its flag values from the ALU result. It holds them in a one-entry pending stage and drives the flag register's per-flag write enables one cycle later, honouring pipeline stall and flush. It also evaluates branch conditions in ID against forwarded flags and raises a stall request when the needed flags are not yet computed.

## Interface
Parameters:
- DW, 16, ALU result width
- OPW, 4, opcode width

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- ex_valid  in  1  EX holds a real instruction
- ex_opcode  in  OPW  EX opcode
- alu_result  in  DW  EX ALU result
- alu_ovfl  in  1  EX signed overflow
- stall  in  1  pipeline freeze
- flush  in  1  EX instruction is wrong-path
- arch_n / arch_z / arch_v  in  1 each  flag register outputs
- br_valid  in  1  ID holds a conditional branch
- br_cond  in  3  branch condition code
- nFlag / zFlag / vFlag  out  1 each  flag data to flag register
- nEn / zEn / vEn  out  1 each  flag register write enables
- br_stall  out  1  ID must stall, flags unresolved
- br_taken  out  1  branch resolved taken

## Operation
- Flag classes: ADD 0000, SUB 0010 set N, Z, V. AND 0011, NOR 0100, SLL 0101, SRL 0110, SRA 0111 set Z only. All other opcodes set none.
- Computed values:
  - N = alu_result[DW-1]
  - Z = (alu_result == 0)
  - V = alu_ovfl
- Pending stage: per-flag valid bits pn/pz/pv plus data bits dn/dz/dv.
- Capture condition: cap = ex_valid & ~flush & ~stall.
- Each edge, when stall=0:
  - each valid bit loads cap & (opcode sets that flag)
  - data bits load computed values
  - flags not set by the captured op get valid=0
- Each edge, when stall=1: valid and data bits hold.
- Write drive: xEn = px & ~stall; xFlag = dx. The flag register captures at the following edge.
- Forwarded flag per bit: fx = px ? dx : arch_x.
- br_cond evaluation on forwarded flags:
  - 000 NE: ~Z
  - 001 EQ: Z
  - 010 GT: ~Z & ~N
  - 011 LT: N
  - 100 GTE: Z | ~N
  - 101 LTE: N | Z
  - 110 OVFL: V
  - 111 UNCOND: 1
- br_stall = br_valid & ex_valid & ~flush & (the EX op sets any flag read by br_cond). Condition 111 never stalls.
- br_taken = br_valid & ~br_stall & cond(forwarded).

## Timing
- Reset: all valid bits 0, data bits 0; every output 0 in the cycle following reset. A pending update present at reset is discarded and never written.
- Latency: EX op at cycle t is captured at edge t. xEn is high during t+1, and the flag register updates at edge t+1.
- Back-to-back flag ops: the old entry drains via xEn while the new one is captured at the same edge. There is no bubble.
- Z-only op following an ADD: cycle t+2 shows zEn=1, nEn=vEn=0. N and V forward from arch.
- Stall with pending entry: enables forced 0, entry held, forwarding continues from the held entry. Enables reassert in the first non-stall cycle.
- Stall and flush together: stall dominates; nothing is captured.
- Flush: kills capture only. An older pending entry still drains.
- Branch resolution is combinational within the cycle. br_stall and br_taken are never both 1.

## Structure
- flag_ctrl_pkg holds:
  - opcode localparams
  - condition-code localparams (CC_NE … CC_UNCOND)
  - function sets_flags(opcode) returning a 3-bit {n,z,v} mask
- One sub-module, flag_cond_eval: combinational, inputs cond and {n,z,v}, output taken. Also reusable by a future branch predictor checker.

## Test plan
- Reset with a pending ADD in flight → no xEn pulse. All outputs 0. arch flags unchanged.
- ADD result 0x8000, ovfl=1 at t → cycle t+1: nEn=zEn=vEn=1, nFlag=1, zFlag=0, vFlag=1.
- SUB result 0 in EX, branch EQ (001) in ID same cycle → br_stall=1, br_taken=0. Next cycle: br_stall=0, br_taken=1 via forwarding, before arch_z updates.
- AND result 0x0000 with stall=1 for 3 cycles starting t+1 → zEn=0 throughout the stall, forwarded Z=1 held. zEn=1 on the first non-stall cycle, only once.
- SLL with flush=1 → no capture, no enables. A branch OVFL (110) with arch_v=1 gives br_taken=1 and no stall.
- ADD then AND back-to-back → t+1: all enables. t+2: zEn only. Branch GT at t+2 uses pending Z and arch N.

Source files
------------

// File: rtl/flag_ctrl_pkg.sv
// flag_ctrl_pkg: opcodes, branch condition codes and
// flag-class helpers shared by the flag controller.
package flag_ctrl_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_ADD = 4'b0000;
  localparam logic [OP_W-1:0] OP_SUB = 4'b0010;
  localparam logic [OP_W-1:0] OP_AND = 4'b0011;
  localparam logic [OP_W-1:0] OP_NOR = 4'b0100;
  localparam logic [OP_W-1:0] OP_SLL = 4'b0101;
  localparam logic [OP_W-1:0] OP_SRL = 4'b0110;
  localparam logic [OP_W-1:0] OP_SRA = 4'b0111;

  localparam logic [2:0] CC_NE     = 3'b000;
  localparam logic [2:0] CC_EQ     = 3'b001;
  localparam logic [2:0] CC_GT     = 3'b010;
  localparam logic [2:0] CC_LT     = 3'b011;
  localparam logic [2:0] CC_GTE    = 3'b100;
  localparam logic [2:0] CC_LTE    = 3'b101;
  localparam logic [2:0] CC_OVFL   = 3'b110;
  localparam logic [2:0] CC_UNCOND = 3'b111;

  // {n,z,v} mask of flags an opcode writes
  function automatic logic [2:0] sets_flags(
    input logic [OP_W-1:0] op
  );
    logic [2:0] m;
    m = 3'b000;
    case (op)
      OP_ADD, OP_SUB: m = 3'b111;
      OP_AND, OP_NOR,
      OP_SLL, OP_SRL,
      OP_SRA:         m = 3'b010;
      default:        m = 3'b000;
    endcase
    return m;
  endfunction

  // {n,z,v} mask of flags a condition reads
  function automatic logic [2:0] cond_reads(
    input logic [2:0] cc
  );
    logic [2:0] m;
    m = 3'b000;
    case (cc)
      CC_NE, CC_EQ:  m = 3'b010;
      CC_GT, CC_GTE,
      CC_LTE:        m = 3'b110;
      CC_LT:         m = 3'b100;
      CC_OVFL:       m = 3'b001;
      default:       m = 3'b000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/flag_cond_eval.sv
// flag_cond_eval: evaluates a branch condition
// code against an {n,z,v} flag triple.
module flag_cond_eval
  import flag_ctrl_pkg::*;
(
  input  logic [2:0] i_cond,
  input  logic [2:0] i_nzv,
  output logic       o_taken
);

  logic w_n;
  logic w_z;
  logic w_v;

  assign w_n = i_nzv[2];
  assign w_z = i_nzv[1];
  assign w_v = i_nzv[0];

  // condition decode
  always_comb begin
    o_taken = 1'b0;
    case (i_cond)
      CC_NE:     o_taken = ~w_z;
      CC_EQ:     o_taken = w_z;
      CC_GT:     o_taken = ~w_z & ~w_n;
      CC_LT:     o_taken = w_n;
      CC_GTE:    o_taken = w_z | ~w_n;
      CC_LTE:    o_taken = w_n | w_z;
      CC_OVFL:   o_taken = w_v;
      CC_UNCOND: o_taken = 1'b1;
      default:   o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_ctrl.sv
// flag_ctrl: one-entry pending N/Z/V update stage,
// flag register write drive and ID branch resolution.
module flag_ctrl
  import flag_ctrl_pkg::*;
#(
  parameter int DW  = 16,
  parameter int OPW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ex_valid,
  input  logic [OPW-1:0] ex_opcode,
  input  logic [DW-1:0]  alu_result,
  input  logic           alu_ovfl,
  input  logic           stall,
  input  logic           flush,
  input  logic           arch_n,
  input  logic           arch_z,
  input  logic           arch_v,
  input  logic           br_valid,
  input  logic [2:0]     br_cond,
  output logic           nFlag,
  output logic           zFlag,
  output logic           vFlag,
  output logic           nEn,
  output logic           zEn,
  output logic           vEn,
  output logic           br_stall,
  output logic           br_taken
);

  logic [2:0] r_pv;
  logic [2:0] r_pd;

  logic       w_cap;
  logic       w_live;
  logic [2:0] w_ex_mask;
  logic [2:0] w_calc;
  logic [2:0] w_arch;
  logic [2:0] w_fwd;
  logic       w_cond;

  assign w_cap     = ex_valid & ~flush & ~stall;
  assign w_live    = ex_valid & ~flush;
  assign w_ex_mask = sets_flags(ex_opcode);
  assign w_calc    = {alu_result[DW-1],
                      alu_result == '0,
                      alu_ovfl};
  assign w_arch    = {arch_n, arch_z, arch_v};

  // pending stage: load on every unstalled edge,
  // valid only for flags the captured op writes
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pv <= 3'b000;
      r_pd <= 3'b000;
    end else if (!stall) begin
      r_pv <= {3{w_cap}} & w_ex_mask;
      r_pd <= w_calc;
    end
  end

  assign {nEn, zEn, vEn}       = r_pv & {3{~stall}};
  assign {nFlag, zFlag, vFlag} = r_pd;

  // pending data overrides the flag register per bit
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_fwd[i] = r_pv[i] ? r_pd[i] : w_arch[i];
    end
  end

  flag_cond_eval u_cond (
    .i_cond  (br_cond),
    .i_nzv   (w_fwd),
    .o_taken (w_cond)
  );

  assign br_stall = br_valid & w_live &
                    (|(w_ex_mask & cond_reads(br_cond)));
  assign br_taken = br_valid & ~br_stall & w_cond;

endmodule

// File: tb/tb_flag_ctrl.sv
// tb_flag_ctrl: directed scenario checks for
// the flag sequencing controller.
module tb_flag_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [3:0]  ex_opcode;
  logic [15:0] alu_result;
  logic        alu_ovfl;
  logic        stall;
  logic        flush;
  logic        arch_n;
  logic        arch_z;
  logic        arch_v;
  logic        br_valid;
  logic [2:0]  br_cond;
  logic        nFlag;
  logic        zFlag;
  logic        vFlag;
  logic        nEn;
  logic        zEn;
  logic        vEn;
  logic        br_stall;
  logic        br_taken;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  flag_ctrl #(.DW(16), .OPW(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .ex_valid   (ex_valid),
    .ex_opcode  (ex_opcode),
    .alu_result (alu_result),
    .alu_ovfl   (alu_ovfl),
    .stall      (stall),
    .flush      (flush),
    .arch_n     (arch_n),
    .arch_z     (arch_z),
    .arch_v     (arch_v),
    .br_valid   (br_valid),
    .br_cond    (br_cond),
    .nFlag      (nFlag),
    .zFlag      (zFlag),
    .vFlag      (vFlag),
    .nEn        (nEn),
    .zEn        (zEn),
    .vEn        (vEn),
    .br_stall   (br_stall),
    .br_taken   (br_taken)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ex_valid   = 1'b0;
    ex_opcode  = 4'b1111;
    alu_result = 16'h1234;
    alu_ovfl   = 1'b0;
    stall      = 1'b0;
    flush      = 1'b0;
    br_valid   = 1'b0;
    br_cond    = 3'b000;
  endtask

  task automatic test_reset();
    logic [7:0] o;
    rst = 1'b0;
    arch_n = 1'b0; arch_z = 1'b0; arch_v = 1'b0;
    idle();
    ex_valid = 1'b1; ex_opcode = 4'b0000;
    alu_result = 16'h8000; alu_ovfl = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    #1;
    o = {nEn, zEn, vEn, nFlag, zFlag, vFlag,
         br_stall, br_taken};
    n_cmp++;
    if (o !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_outs got=%b want=00000000", o);
    end
    tick();
    o = {nEn, zEn, vEn, nFlag, zFlag, vFlag,
         br_stall, br_taken};
    n_cmp++;
    if (o !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_drain got=%b want=00000000", o);
    end
  endtask

  task automatic test_add();
    idle();
    ex_valid = 1'b1; ex_opcode = 4'b0000;
    alu_result = 16'h8000; alu_ovfl = 1'b1;
    tick();
    idle();
    br_valid = 1'b1; br_cond = 3'b011;
    #1;
    n_cmp++;
    if ({nEn, zEn, vEn} !== 3'b111) begin
      n_bad++;
      $display("FAIL add_en got=%b want=111", {nEn, zEn, vEn});
    end
    n_cmp++;
    if ({nFlag, zFlag, vFlag} !== 3'b101) begin
      n_bad++;
      $display("FAIL add_flags got=%b want=101",
               {nFlag, zFlag, vFlag});
    end
    n_cmp++;
    if ({br_stall, br_taken} !== 2'b01) begin
      n_bad++;
      $display("FAIL add_lt_fwd got=%b want=01",
               {br_stall, br_taken});
    end
    tick();
    idle();
    #1;
    n_cmp++;
    if ({nEn, zEn, vEn} !== 3'b000) begin
      n_bad++;
      $display("FAIL add_once got=%b want=000", {nEn, zEn, vEn});
    end
  endtask

  task automatic test_sub_branch();
    arch_z = 1'b0;
    idle();
    ex_valid = 1'b1; ex_opcode = 4'b0010;
    alu_result = 16'h0000;
    br_valid = 1'b1; br_cond = 3'b001;
    #1;
    n_cmp++;
    if ({br_stall, br_taken} !== 2'b10) begin
      n_bad++;
      $display("FAIL sub_eq_stall got=%b want=10",
               {br_stall, br_taken});
    end
    tick();
    ex_valid = 1'b0;
    #1;
    n_cmp++;
    if ({br_stall, br_taken} !== 2'b01) begin
      n_bad++;
      $display("FAIL sub_eq_fwd got=%b want=01",
               {br_stall, br_taken});
    end
    n_cmp++;
    if ({zEn, zFlag} !== 2'b11) begin
      n_bad++;
      $display("FAIL sub_z got=%b want=11", {zEn, zFlag});
    end
    tick();
    idle();
  endtask

  task automatic test_stall();
    arch_n = 1'b0; arch_z = 1'b0; arch_v = 1'b0;
    idle();
    ex_valid = 1'b1; ex_opcode = 4'b0011;
    alu_result = 16'h0000;
    tick();
    idle();
    stall = 1'b1;
    br_valid = 1'b1; br_cond = 3'b001;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if ({nEn, zEn, vEn} !== 3'b000) begin
        n_bad++;
        $display("FAIL stall_en[%0d] got=%b want=000",
                 i, {nEn, zEn, vEn});
      end
      n_cmp++;
      if ({br_stall, br_taken} !== 2'b01) begin
        n_bad++;
        $display("FAIL stall_fwdz[%0d] got=%b want=01",
                 i, {br_stall, br_taken});
      end
      tick();
    end
    stall = 1'b0;
    #1;
    n_cmp++;
    if ({nEn, zEn, vEn, zFlag} !== 4'b0101) begin
      n_bad++;
      $display("FAIL stall_release got=%b want=0101",
               {nEn, zEn, vEn, zFlag});
    end
    tick();
    n_cmp++;
    if (zEn !== 1'b0) begin
      n_bad++;
      $display("FAIL stall_single got=%b want=0", zEn);
    end
    idle();
  endtask

  task automatic test_flush();
    arch_v = 1'b1;
    idle();
    ex_valid = 1'b1; ex_opcode = 4'b0101;
    alu_result = 16'h0000; flush = 1'b1;
    br_valid = 1'b1; br_cond = 3'b110;
    #1;
    n_cmp++;
    if ({br_stall, br_taken} !== 2'b01) begin
      n_bad++;
      $display("FAIL flush_ovfl got=%b want=01",
               {br_stall, br_taken});
    end
    tick();
    idle();
    #1;
    n_cmp++;
    if ({nEn, zEn, vEn} !== 3'b000) begin
      n_bad++;
      $display("FAIL flush_cap got=%b want=000", {nEn, zEn, vEn});
    end
    ex_valid = 1'b1; ex_opcode = 4'b0000;
    alu_result = 16'h0001;
    tick();
    flush = 1'b1;
    #1;
    n_cmp++;
    if ({nEn, zEn, vEn} !== 3'b111) begin
      n_bad++;
      $display("FAIL flush_drain got=%b want=111", {nEn, zEn, vEn});
    end
    tick();
    idle();
    #1;
    n_cmp++;
    if ({nEn, zEn, vEn} !== 3'b000) begin
      n_bad++;
      $display("FAIL flush_kill got=%b want=000", {nEn, zEn, vEn});
    end
    ex_valid = 1'b1; ex_opcode = 4'b0000;
    stall = 1'b1; flush = 1'b1;
    tick();
    idle();
    #1;
    n_cmp++;
    if ({nEn, zEn, vEn} !== 3'b000) begin
      n_bad++;
      $display("FAIL stall_flush got=%b want=000", {nEn, zEn, vEn});
    end
    arch_v = 1'b0;
  endtask

  task automatic test_back_to_back();
    arch_n = 1'b0; arch_z = 1'b0; arch_v = 1'b0;
    idle();
    ex_valid = 1'b1; ex_opcode = 4'b0000;
    alu_result = 16'h8000; alu_ovfl = 1'b1;
    tick();
    ex_opcode = 4'b0011;
    alu_result = 16'h00f0; alu_ovfl = 1'b0;
    #1;
    n_cmp++;
    if ({nEn, zEn, vEn, nFlag, zFlag, vFlag} !== 6'b111101) begin
      n_bad++;
      $display("FAIL b2b_t1 got=%b want=111101",
               {nEn, zEn, vEn, nFlag, zFlag, vFlag});
    end
    tick();
    idle();
    br_valid = 1'b1; br_cond = 3'b010;
    #1;
    n_cmp++;
    if ({nEn, zEn, vEn, zFlag} !== 4'b0100) begin
      n_bad++;
      $display("FAIL b2b_t2 got=%b want=0100",
               {nEn, zEn, vEn, zFlag});
    end
    n_cmp++;
    if ({br_stall, br_taken} !== 2'b01) begin
      n_bad++;
      $display("FAIL b2b_gt_archn0 got=%b want=01",
               {br_stall, br_taken});
    end
    arch_n = 1'b1;
    #1;
    n_cmp++;
    if ({br_stall, br_taken} !== 2'b00) begin
      n_bad++;
      $display("FAIL b2b_gt_archn1 got=%b want=00",
               {br_stall, br_taken});
    end
    br_cond = 3'b111;
    ex_valid = 1'b1; ex_opcode = 4'b0000;
    #1;
    n_cmp++;
    if ({br_stall, br_taken} !== 2'b01) begin
      n_bad++;
      $display("FAIL uncond_nostall got=%b want=01",
               {br_stall, br_taken});
    end
    tick();
    idle();
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_branch();
    test_stall();
    test_flush();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
